// File: rtl/spi_ram_ctrl.sv
// SPI-slave RAM controller: decodes {cmd, payload} words into pointer loads and
// memory writes, and serves single-word reads to the SPI transmit path.
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    input  logic                  tx_ack,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  addr_err,
    output logic                  rd_overrun,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam int                    MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q, tx_valid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  rd_overrun_q, rd_overrun_d;
    logic                  mem_we;

    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  addr_ok;
    logic                  is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;

    assign cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
    assign payload = din[DATA_WIDTH-1:0];
    assign addr_in = payload[ADDR_WIDTH-1:0];
    assign addr_ok = ({1'b0, addr_in} < DEPTH_W);

    assign is_wr_addr = rx_valid && (cmd == CMD_WR_ADDR);
    assign is_wr_data = rx_valid && (cmd == CMD_WR_DATA);
    assign is_rd_addr = rx_valid && (cmd == CMD_RD_ADDR);
    assign is_rd_data = rx_valid && (cmd == CMD_RD_DATA);

    // Wraps at the last implemented word, not at the pointer's natural rollover.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        if (AUTO_INC == 0) begin
            return p;
        end
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tx_valid_d   = tx_valid_q;
        addr_err_d   = 1'b0;
        rd_overrun_d = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_rd_data) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                tx_valid_d = 1'b1;
                rd_ptr_d   = next_ptr(rd_ptr_q);
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (tx_ack) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        if (is_rd_data && (state_q != S_IDLE)) begin
            rd_overrun_d = 1'b1;
        end

        if (is_wr_addr) begin
            if (addr_ok) begin
                wr_ptr_d = addr_in;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        if (is_wr_data) begin
            mem_we   = 1'b1;
            wr_ptr_d = next_ptr(wr_ptr_q);
        end

        // Placed after the FETCH increment so an explicit load wins over it.
        if (is_rd_addr) begin
            if (addr_ok) begin
                rd_ptr_d = addr_in;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_valid_q   <= tx_valid_d;
            addr_err_q   <= addr_err_d;
            rd_overrun_q <= rd_overrun_d;
        end
    end

    // Registered read sees the pre-write word when a write hits the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (state_q == S_FETCH) begin
            dout_q <= mem_q[rd_ptr_q[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q[MEM_AW-1:0]] <= payload;
        end
    end

    assign dout        = dout_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign addr_err    = addr_err_q;
    assign rd_overrun  = rd_overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Parametrised SPI-slave RAM controller and successor to the fixed 8-bit/256-word SPI RAM.
- Accepts {cmd[1:0], payload} words from the SPI receive path, holds separate write and read address pointers, and stores data in an internal memory array.
- Returns read data to the SPI transmit path through a valid/acknowledge handshake.
- New over the previous generation: configurable data width, address width and depth; optional pointer auto-increment for bursts; out-of-range address flagging; read-overrun flagging.

Parameters:
- DATA_WIDTH, 8, width of a memory word and of the payload field; must be >= ADDR_WIDTH.
- ADDR_WIDTH, 8, width of the address pointers.
- MEM_DEPTH, 256, number of memory words; 1 <= MEM_DEPTH <= 2**ADDR_WIDTH.
- AUTO_INC, 1, 1 = pointer increments after each data access; 0 = pointer holds.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH+2  command word: din[DATA_WIDTH+1:DATA_WIDTH] = cmd, din[DATA_WIDTH-1:0] = payload.
- rx_valid  in  1  din is valid this cycle; one command is consumed per cycle while high.
- tx_ack  in  1  SPI transmit path has taken dout.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  dout holds valid read data.
- busy  out  1  read in progress or awaiting tx_ack.
- addr_err  out  1  one-cycle pulse: address payload >= MEM_DEPTH was rejected.
- rd_overrun  out  1  one-cycle pulse: RD_DATA was dropped because busy.

Behaviour:
- Reset is synchronous, sampled on clk rising edge while rst=1. On reset:
  - dout=0, tx_valid=0, busy=0, addr_err=0, rd_overrun=0.
  - wr_ptr=0, rd_ptr=0, state=IDLE.
  - Memory contents are not cleared.
  - rst overrides any concurrent command or tx_ack, including mid-read.
- Commands are sampled at edge E when rx_valid=1; rx_valid=0 means no action.
- cmd 00 WR_ADDR: if payload[ADDR_WIDTH-1:0] < MEM_DEPTH, wr_ptr <= that value; otherwise wr_ptr is unchanged and addr_err=1 for the cycle after E. Payload bits above ADDR_WIDTH are ignored.
- cmd 01 WR_DATA: mem[wr_ptr] <= payload. If AUTO_INC=1, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1.
- cmd 10 RD_ADDR: same range rule as WR_ADDR, applied to rd_ptr.
- cmd 11 RD_DATA:
  - In IDLE: state <= FETCH.
  - Otherwise: the command is dropped, rd_overrun=1 for one cycle, and rd_ptr is unchanged.
- State machine (busy = state != IDLE):
  - IDLE --RD_DATA--> FETCH.
  - FETCH, always one cycle: at edge E+1, dout <= mem[rd_ptr], tx_valid <= 1, rd_ptr auto-increments with wrap when AUTO_INC=1; state <= HOLD.
  - HOLD: dout and tx_valid are held stable. When tx_ack=1 at an edge: tx_valid <= 0, state <= IDLE, dout keeps its last value.
- Latency: RD_DATA sampled at E → tx_valid visible after E+1. Minimum spacing between back-to-back reads is 3 cycles (FETCH, HOLD with immediate ack, IDLE).
- tx_ack while tx_valid=0 is ignored.
- WR_ADDR, WR_DATA and RD_ADDR are accepted in any state.
  - WR_DATA at E+1 (during FETCH) to the address being read: dout returns the old word (read-before-write); the memory takes the new word.
  - RD_ADDR during FETCH/HOLD updates rd_ptr for the next read only. The auto-increment at E+1 applies to the fetched address; a RD_ADDR sampled at E+1 takes priority over the increment.
- MEM_DEPTH < 2**ADDR_WIDTH: auto-increment wraps at MEM_DEPTH-1, never 2**ADDR_WIDTH-1.
- addr_err and rd_overrun are independent, never sticky, and may not both fire in the same cycle (only one command per cycle).

Test Plan:
- Reset: drive rst=1 for 3 cycles with rx_valid=1, din={11,0x00} → dout=0, tx_valid=0, busy=0 throughout; release rst → no spurious tx_valid.
- Basic write/read (defaults): {00,0x00}, {01,0x01}, {10,0x00}, {11,xx}, tx_ack=1 on the cycle after tx_valid rises → tx_valid high exactly 1 cycle after the RD_DATA edge, dout=0x01, tx_valid low after the ack.
- Burst, AUTO_INC=1: {00,0xFE}, then write 0xAA, 0xBB, 0xCC → mem[0xFE]=0xAA, mem[0xFF]=0xBB, mem[0x00]=0xCC; {10,0xFE} then three acked reads → 0xAA, 0xBB, 0xCC.
- Range check, MEM_DEPTH=200: {00,0xC8} → addr_err one-cycle pulse, wr_ptr unchanged; {00,0xC7}, write ×2 → second write lands at address 0.
- Overrun: RD_DATA, hold tx_ack=0 for 5 cycles, issue a second RD_DATA → rd_overrun pulse, dout unchanged, tx_valid stays 1, rd_ptr unchanged.
- Collision and mid-read reset: RD_DATA at address 5 (contains 0x11), then at E+1 {01,0x22} with wr_ptr=5 → dout=0x11 and mem[5]=0x22; separately, rst=1 during HOLD → tx_valid=0 and busy=0 on the next cycle.
